dig_led_driver: RTL and testbench

Memory-mapped eight-digit seven-segment display peripheral that sits on the digit-LED port of the SoC bus bridge. It accepts CPU store transactions forwarded by the bridge and latches a 32-bit display word and an 8-bit digit-enable mask. It continuously time-multiplexes the eight common-anode digits. Each digit shows one hex nibble, with a blanking gap between digit slots to suppress ghosting.

---
 rtl/dig_led_driver.sv | 146 ++++++++++++++
 tb/tb_dig_led_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dig_led_driver.sv
// -----------------------------------------------------------------------------
// dig_led_driver
//   Memory-mapped eight-digit, common-anode seven-segment display driver.
//   The CPU stores a 32-bit display word (one hex nibble per digit) and an
//   8-bit digit-enable mask. The block scans the digits one slot at a time,
//   and keeps every digit dark for the first BLANK cycles of each slot to
//   suppress ghosting.
//
// Ports
//   clk             CPU clock from the bus bridge
//   rst             asynchronous, active-high reset
//   addr[31:0]      bus address (full-width compare)
//   wen             write enable, sampled on every rising edge
//   wdata[31:0]     write data
//   dig_en[7:0]     digit selects, active-low (bit 0 = rightmost digit)
//   DN_A..DN_G      segment drives, active-low
//   DN_DP           decimal point, active-low, always off
// -----------------------------------------------------------------------------
module dig_led_driver #(
    parameter int unsigned SCAN_DIV  = 20000,
    parameter int unsigned BLANK     = 2,
    parameter logic [31:0] ADDR_DATA = 32'hFFFF_F000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic        DN_A,
    output logic        DN_B,
    output logic        DN_C,
    output logic        DN_D,
    output logic        DN_E,
    output logic        DN_F,
    output logic        DN_G,
    output logic        DN_DP
);

    localparam int unsigned    CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    // Active-low hex font; bit order is {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [31:0]   r_data;
    logic [7:0]    r_mask;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_dig_en;
    logic [6:0]    r_seg;

    logic [3:0]    w_nib;
    logic          w_blank;
    logic [7:0]    w_dig_en;
    logic [6:0]    w_seg;

    // Bus register writes; unmatched addresses are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= 32'h0000_0000;
            r_mask <= 8'hFF;
        end else if (wen && (addr == ADDR_DATA)) begin
            r_data <= wdata;
        end else if (wen && (addr == ADDR_MASK)) begin
            r_mask <= wdata[7:0];
        end else begin
            r_data <= r_data;
            r_mask <= r_mask;
        end
    end

    // Slot timer and digit index; the index steps on the last cycle of a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
            r_idx <= r_idx;
        end
    end

    // Next-output decode from the current scan state and registers.
    always_comb begin
        w_nib    = r_data[{r_idx, 2'b00} +: 4];
        w_blank  = (r_cnt < CNT_BLANK) || !r_mask[r_idx];
        w_seg    = hex_to_seg(w_nib);
        w_dig_en = 8'hFF;
        if (w_blank) begin
            w_dig_en = 8'hFF;
        end else begin
            w_dig_en = ~(8'h01 << r_idx);
        end
    end

    // Output registers; segments follow the selected nibble even while blanked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig_en <= 8'hFF;
            r_seg    <= 7'b1111111;
        end else begin
            r_dig_en <= w_dig_en;
            r_seg    <= w_seg;
        end
    end

    assign dig_en = r_dig_en;
    assign DN_A   = r_seg[0];
    assign DN_B   = r_seg[1];
    assign DN_C   = r_seg[2];
    assign DN_D   = r_seg[3];
    assign DN_E   = r_seg[4];
    assign DN_F   = r_seg[5];
    assign DN_G   = r_seg[6];
    assign DN_DP  = 1'b1;

endmodule

// File: tb/tb_dig_led_driver.sv
// -----------------------------------------------------------------------------
// tb_dig_led_driver
//   Directed bench for dig_led_driver with SCAN_DIV=8, BLANK=2. Inputs are
//   driven 1 ns after the rising edge and outputs are sampled at that point,
//   so each sample shows the outputs registered at the preceding edge.
// -----------------------------------------------------------------------------
module tb_dig_led_driver;

    localparam logic [31:0] A_DATA = 32'hFFFF_F000;
    localparam logic [31:0] A_MASK = 32'hFFFF_F004;
    localparam logic [31:0] A_BAD  = 32'hFFFF_F008;

    // Active-low {G,F,E,D,C,B,A}
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SF   = 7'b0001110;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  dig_en;
    logic        DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP;
    logic [6:0]  seg;

    int vectors;
    int miscompares;

    assign seg = {DN_G, DN_F, DN_E, DN_D, DN_C, DN_B, DN_A};

    dig_led_driver #(
        .SCAN_DIV  (8),
        .BLANK     (2),
        .ADDR_DATA (A_DATA),
        .ADDR_MASK (A_MASK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wen    (wen),
        .wdata  (wdata),
        .dig_en (dig_en),
        .DN_A   (DN_A),
        .DN_B   (DN_B),
        .DN_C   (DN_C),
        .DN_D   (DN_D),
        .DN_E   (DN_E),
        .DN_F   (DN_F),
        .DN_G   (DN_G),
        .DN_DP  (DN_DP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_dig, input logic [6:0] exp_seg);
        vectors++;
        assert (dig_en === exp_dig) else begin
            miscompares++;
            $error("FAIL %s dig_en observed %h expected %h", tag, dig_en, exp_dig);
        end
        vectors++;
        assert (seg === exp_seg) else begin
            miscompares++;
            $error("FAIL %s seg observed %b expected %b", tag, seg, exp_seg);
        end
    endtask

    task automatic chk_dp(input string tag);
        vectors++;
        assert (DN_DP === 1'b1) else begin
            miscompares++;
            $error("FAIL %s DN_DP observed %b expected 1", tag, DN_DP);
        end
    endtask

    // One full 8-cycle slot: two blank cycles then the active digit.
    task automatic check_slot(input string tag, input logic [7:0] exp_dig, input logic [6:0] exp_seg);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk(tag, (c < 2) ? 8'hFF : exp_dig, exp_seg);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        tick();
        wen   = 1'b0;
        addr  = 32'h0000_0000;
        wdata = 32'h0000_0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        wen   = 1'b0;
        addr  = 32'h0000_0000;
        wdata = 32'h0000_0000;

        // Reset held
        tick_n(2);
        chk("reset_hold", 8'hFF, SOFF);
        chk_dp("reset_hold_dp");
        rst = 1'b0;

        // First slot after release: two blank samples then digit 0 active
        tick();
        chk("rel_c0", 8'hFF, S0);
        tick();
        chk("rel_c1", 8'hFF, S0);
        tick();
        tick();
        chk("rel_c3", 8'hFE, S0);

        // Asynchronous reset mid-slot, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 8'hFF, SOFF);
        chk_dp("async_rst_dp");
        tick();
        rst = 1'b0;

        check_slot("post_rst_slot0", 8'hFE, S0);

        // Data write captured on the last cycle of slot 7
        tick_n(55);
        bus_write(A_DATA, 32'h1234_5678);
        chk("pre_data_slot7", 8'h7F, S0);
        check_slot("data_slot0", 8'hFE, S8);
        check_slot("data_slot1", 8'hFD, S7);
        check_slot("data_slot2", 8'hFB, S6);
        check_slot("data_slot3", 8'hF7, S5);
        check_slot("data_slot4", 8'hEF, S4);
        check_slot("data_slot5", 8'hDF, S3);
        check_slot("data_slot6", 8'hBF, S2);
        check_slot("data_slot7", 8'h7F, S1);
        check_slot("data_wrap0", 8'hFE, S8);

        // Mask out digits 4..7, written on the last cycle of slot 1
        tick_n(7);
        bus_write(A_MASK, 32'h0000_000F);
        chk("mask_wr_slot1", 8'hFD, S7);
        check_slot("mask_slot2", 8'hFB, S6);
        check_slot("mask_slot3", 8'hF7, S5);
        check_slot("mask_slot4", 8'hFF, S4);
        check_slot("mask_slot5", 8'hFF, S3);
        check_slot("mask_slot6", 8'hFF, S2);
        check_slot("mask_slot7", 8'hFF, S1);
        check_slot("mask_slot0", 8'hFE, S8);
        check_slot("mask_slot1", 8'hFD, S7);

        // Unmapped address must not disturb data or mask
        tick_n(7);
        bus_write(A_BAD, 32'hFFFF_FFFF);
        chk("bad_wr_slot2", 8'hFB, S6);
        check_slot("bad_slot3", 8'hF7, S5);
        check_slot("bad_slot4", 8'hFF, S4);
        check_slot("bad_slot5", 8'hFF, S3);
        check_slot("bad_slot6", 8'hFF, S2);
        check_slot("bad_slot7", 8'hFF, S1);
        check_slot("bad_slot0", 8'hFE, S8);
        check_slot("bad_slot1", 8'hFD, S7);

        // Write coinciding with the idx 0 -> 1 advance
        tick_n(55);
        bus_write(A_DATA, 32'hAAAA_AAAA);
        chk("wrap_wr_slot0", 8'hFE, S8);
        check_slot("wrap_slot1", 8'hFD, SA);

        // Back-to-back writes inside active slot 2
        tick_n(2);
        bus_write(A_DATA, 32'h0000_0000);
        chk("b2b_first", 8'hFB, SA);
        bus_write(A_DATA, 32'hFFFF_FFFF);
        chk("b2b_second", 8'hFB, S0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_last_wins", 8'hFB, SF);
        end
        check_slot("b2b_slot3", 8'hF7, SF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
